// File: rtl/bin_count_source.sv
// Registered up/down counter with load, wrap pulse and a valid/ready output slot; 1-cycle latency,
// count stalls while out_valid && !out_ready. Optional gray_out port under `GRAY_OUT_EN.
module bin_count_source #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic             wrap
`ifdef GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray_out
`endif
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             slot_free;

  assign slot_free = (state_q == IDLE) || out_ready;

  // Requests arriving while the slot is occupied are dropped, not queued.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (slot_free) begin
      state_d = (load || en) ? HOLD : IDLE;
      if (load) begin
        count_d = (load_val > LIM) ? LIM : load_val;
      end else if (en && up) begin
        wrap_d  = (count_q == LIM);
        count_d = wrap_d ? '0 : count_q + 1'b1;
      end else if (en) begin
        wrap_d  = (count_q == '0);
        count_d = wrap_d ? LIM : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign dout      = count_q;
  assign wrap      = wrap_q;

`ifdef GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  // Encoded from count_d so the Gray word lands on the same edge as dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_d ^ (count_d >> 1);
    end
  end

  assign gray_out = gray_q;
`endif

endmodule

// File: tb/tb_bin_count_source.sv
// Bench for bin_count_source: directed spec scenarios plus randomized traffic vs. a modular-arithmetic model.
// Instance a uses the default LIMIT=15, instance b uses LIMIT=9 to exercise load clamping.
module tb_bin_count_source;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0, up = 1'b0, load = 1'b0, out_ready = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         vld_a, wrap_a, vld_b, wrap_b;
  logic [W-1:0] dout_a, dout_b;
`ifdef GRAY_OUT_EN
  logic [W-1:0] gray_a, gray_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  int lim[2] = '{15, 9};
  int m_cnt[2];
  bit m_vld[2];
  bit m_wrap[2];

  bin_count_source #(.WIDTH(W)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .out_ready(out_ready), .out_valid(vld_a), .dout(dout_a), .wrap(wrap_a)
`ifdef GRAY_OUT_EN
    , .gray_out(gray_a)
`endif
  );

  bin_count_source #(.WIDTH(W), .LIMIT(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .out_ready(out_ready), .out_valid(vld_b), .dout(dout_b), .wrap(wrap_b)
`ifdef GRAY_OUT_EN
    , .gray_out(gray_b)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, advance the reference model, sample 1 time unit after the edge.
  task automatic step(input bit l, input int lv, input bit e, input bit u, input bit r);
    int nc[2];
    bit nv[2];
    bit nw[2];
    load = l; load_val = lv[W-1:0]; en = e; up = u; out_ready = r;
    for (int k = 0; k < 2; k++) begin
      nc[k] = m_cnt[k]; nv[k] = m_vld[k]; nw[k] = 1'b0;
      if (!m_vld[k] || r) begin
        if (l) begin
          nc[k] = (lv > lim[k]) ? lim[k] : lv;
          nv[k] = 1'b1;
        end else if (e) begin
          nv[k] = 1'b1;
          if (u) begin
            nw[k] = (m_cnt[k] == lim[k]);
            nc[k] = (m_cnt[k] + 1) % (lim[k] + 1);
          end else begin
            nw[k] = (m_cnt[k] == 0);
            nc[k] = (m_cnt[k] + lim[k]) % (lim[k] + 1);
          end
        end else begin
          nv[k] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    m_cnt = nc; m_vld = nv; m_wrap = nw;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_vld[k] = 1'b0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    n_vec++;
    if ({vld_a, wrap_a, dout_a} !== 6'b0) begin
      n_err++; $display("FAIL reset_initial: got v=%0b w=%0b d=%0d, want 0 0 0", vld_a, wrap_a, dout_a);
    end
    @(negedge clk) rst_n = 1'b1;
    step(1, 9, 0, 0, 1);
    n_vec++;
    if ({vld_a, wrap_a, dout_a} !== {1'b1, 1'b0, 4'd9}) begin
      n_err++; $display("FAIL reset_preload: got v=%0b w=%0b d=%0d, want 1 0 9", vld_a, wrap_a, dout_a);
    end
    load = 1'b0; en = 1'b0;
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    n_vec++;
    if ({vld_a, wrap_a, dout_a, vld_b, dout_b} !== 11'b0) begin
      n_err++; $display("FAIL reset_async: got v=%0b w=%0b d=%0d, want 0 0 0 before edge", vld_a, wrap_a, dout_a);
    end
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    n_vec++;
    if ({vld_a, wrap_a, dout_a} !== 6'b0) begin
      n_err++; $display("FAIL reset_first_edge_idle: got v=%0b w=%0b d=%0d, want 0 0 0", vld_a, wrap_a, dout_a);
    end
  endtask

  task automatic test_up_wrap();
    int ed[4] = '{14, 15, 0, 1};
    bit ew[4] = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1, 14, 0, 1, 1);
      else        step(0, 0, 1, 1, 1);
      n_vec++;
      if ({vld_a, wrap_a, dout_a} !== {1'b1, ew[i], 4'(ed[i])}) begin
        n_err++; $display("FAIL up_wrap[%0d]: got v=%0b w=%0b d=%0d, want 1 %0b %0d", i, vld_a, wrap_a, dout_a, ew[i], ed[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    int ed[3] = '{1, 0, 15};
    bit ew[3] = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1, 1, 0, 0, 1);
      else        step(0, 0, 1, 0, 1);
      n_vec++;
      if ({vld_a, wrap_a, dout_a} !== {1'b1, ew[i], 4'(ed[i])}) begin
        n_err++; $display("FAIL down_wrap[%0d]: got v=%0b w=%0b d=%0d, want 1 %0b %0d", i, vld_a, wrap_a, dout_a, ew[i], ed[i]);
      end
    end
  endtask

  task automatic test_stall();
    step(1, 5, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0);
      n_vec++;
      if ({vld_a, wrap_a, dout_a} !== {1'b1, 1'b0, 4'd5}) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%0b w=%0b d=%0d, want 1 0 5", i, vld_a, wrap_a, dout_a);
      end
    end
    step(0, 0, 1, 1, 1);
    n_vec++;
    if ({vld_a, wrap_a, dout_a} !== {1'b1, 1'b0, 4'd6}) begin
      n_err++; $display("FAIL stall_release: got v=%0b w=%0b d=%0d, want 1 0 6", vld_a, wrap_a, dout_a);
    end
    // Stalled at LIMIT with an up request pending: wrap must stay low.
    step(1, 15, 0, 1, 1);
    step(0, 0, 1, 1, 0);
    n_vec++;
    if ({vld_a, wrap_a, dout_a} !== {1'b1, 1'b0, 4'd15}) begin
      n_err++; $display("FAIL stall_no_wrap: got v=%0b w=%0b d=%0d, want 1 0 15", vld_a, wrap_a, dout_a);
    end
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    n_vec++;
    if ({vld_a, wrap_a, dout_a} !== 6'b0) begin
      n_err++; $display("FAIL reset_mid_stall: got v=%0b w=%0b d=%0d, want 0 0 0", vld_a, wrap_a, dout_a);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_load_priority();
    step(1, 7, 1, 1, 1);
    n_vec++;
    if ({vld_a, wrap_a, dout_a, dout_b} !== {1'b1, 1'b0, 4'd7, 4'd7}) begin
      n_err++; $display("FAIL load_over_en: got v=%0b w=%0b d=%0d d9=%0d, want 1 0 7 7", vld_a, wrap_a, dout_a, dout_b);
    end
    step(1, 12, 1, 0, 1);
    n_vec++;
    if ({dout_a, dout_b, wrap_b} !== {4'd12, 4'd9, 1'b0}) begin
      n_err++; $display("FAIL load_clamp: got d=%0d d9=%0d w9=%0b, want 12 9 0", dout_a, dout_b, wrap_b);
    end
    step(1, 15, 1, 1, 1);
    n_vec++;
    if ({wrap_a, dout_a, wrap_b, dout_b} !== {1'b0, 4'd15, 1'b0, 4'd9}) begin
      n_err++; $display("FAIL load_no_wrap: got w=%0b d=%0d w9=%0b d9=%0d, want 0 15 0 9", wrap_a, dout_a, wrap_b, dout_b);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 1, 1);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 1, 1, 1);
      n_vec++;
      if ({vld_a, wrap_a, dout_a} !== {1'b1, (i % 16) == 0, 4'(i % 16)}) begin
        n_err++; $display("FAIL back_to_back[%0d]: got v=%0b w=%0b d=%0d, want 1 %0b %0d", i, vld_a, wrap_a, dout_a, (i % 16) == 0, i % 16);
      end
    end
    step(0, 0, 0, 1, 1);
    n_vec++;
    if (vld_a !== 1'b0) begin
      n_err++; $display("FAIL back_to_back_drain: got v=%0b, want 0", vld_a);
    end
  endtask

`ifdef GRAY_OUT_EN
  task automatic test_gray();
    int gt[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    for (int i = 0; i < 16; i++) begin
      if (i == 0) step(1, 0, 0, 1, 1);
      else        step(0, 0, 1, 1, 1);
      n_vec++;
      if ({dout_a, gray_a} !== {4'(i), 4'(gt[i])}) begin
        n_err++; $display("FAIL gray[%0d]: got d=%0d g=%0d, want %0d %0d", i, dout_a, gray_a, i, gt[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      n_vec++;
      if ({vld_a, wrap_a, dout_a} !== {m_vld[0], m_wrap[0], 4'(m_cnt[0])}) begin
        n_err++; $display("FAIL random_a[%0d]: got v=%0b w=%0b d=%0d, want %0b %0b %0d", i, vld_a, wrap_a, dout_a, m_vld[0], m_wrap[0], m_cnt[0]);
      end
      n_vec++;
      if ({vld_b, wrap_b, dout_b} !== {m_vld[1], m_wrap[1], 4'(m_cnt[1])}) begin
        n_err++; $display("FAIL random_b[%0d]: got v=%0b w=%0b d=%0d, want %0b %0b %0d", i, vld_b, wrap_b, dout_b, m_vld[1], m_wrap[1], m_cnt[1]);
      end
`ifdef GRAY_OUT_EN
      n_vec++;
      if (gray_a !== 4'(m_cnt[0] ^ (m_cnt[0] >> 1))) begin
        n_err++; $display("FAIL random_gray[%0d]: got g=%0d, want %0d", i, gray_a, m_cnt[0] ^ (m_cnt[0] >> 1));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_stall();
    test_load_priority();
    test_back_to_back();
`ifdef GRAY_OUT_EN
    test_gray();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
